// File: rtl/round_sequencer.sv
// Penalty-match sequencer: picks/receives shot targets, animates the ball per frame,
// judges save vs goal against the keeper and keeps round/score counters.
module round_sequencer #(
  parameter int unsigned ROUNDS        = 5,
  parameter int unsigned FLIGHT_FRAMES = 32,
  parameter int unsigned START_X       = 512,
  parameter int unsigned START_Y       = 700,
  parameter int unsigned GOAL_X_MIN    = 35,
  parameter int unsigned GOAL_X_MAX    = 989,
  parameter int unsigned GOAL_Y_MIN    = 115,
  parameter int unsigned GOAL_Y_MAX    = 644,
  parameter int unsigned HIT_RADIUS    = 64,
  parameter int unsigned RESULT_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        solo,
  input  logic        remote_valid,
  input  logic [11:0] remote_x,
  input  logic [11:0] remote_y,
  input  logic [11:0] keeper_x,
  input  logic [11:0] keeper_y,
  output logic [11:0] ball_x,
  output logic [11:0] ball_y,
  output logic [11:0] target_x,
  output logic [11:0] target_y,
  output logic        shot_req,
  output logic        is_scored,
  output logic [3:0]  round_counter,
  output logic [3:0]  score,
  output logic        game_over,
  output logic [2:0]  state_o
);

  localparam int unsigned Shift = $clog2(FLIGHT_FRAMES);
  localparam int unsigned RangeX = GOAL_X_MAX - GOAL_X_MIN;
  localparam int unsigned RangeY = GOAL_Y_MAX - GOAL_Y_MIN;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StAim    = 3'd1,
    StFlight = 3'd2,
    StJudge  = 3'd3,
    StResult = 3'd4,
    StDone   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        solo_q, solo_d;
  logic [11:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [11:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic        shot_req_q, shot_req_d;
  logic        scored_q, scored_d;
  logic [3:0]  round_q, round_d, score_q, score_d;
  logic        over_q, over_d;

  logic [11:0]        rx, ry, solo_tx, solo_ty, clamp_x, clamp_y;
  logic [6:0]         cnt_inc;
  logic signed [12:0] dx, dy, ex, ey, ax, ay;
  logic signed [18:0] px, py, sx, sy, bx, by;
  logic               saved;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    rx = {2'b00, lfsr_q[9:0]};
    if (rx > 12'(RangeX)) rx = rx - 12'(RangeX + 1);
    ry = {2'b00, lfsr_q[15:6]};
    if (ry > 12'(RangeY)) ry = ry - 12'(RangeY + 1);
    solo_tx = 12'(GOAL_X_MIN) + rx;
    solo_ty = 12'(GOAL_Y_MIN) + ry;

    clamp_x = remote_x;
    if (remote_x < 12'(GOAL_X_MIN)) clamp_x = 12'(GOAL_X_MIN);
    else if (remote_x > 12'(GOAL_X_MAX)) clamp_x = 12'(GOAL_X_MAX);
    clamp_y = remote_y;
    if (remote_y < 12'(GOAL_Y_MIN)) clamp_y = 12'(GOAL_Y_MIN);
    else if (remote_y > 12'(GOAL_Y_MAX)) clamp_y = 12'(GOAL_Y_MAX);

    // Interpolation for the frame index after this tick.
    cnt_inc = cnt_q + 7'd1;
    dx = $signed({1'b0, tgt_x_q}) - $signed(13'(START_X));
    dy = $signed({1'b0, tgt_y_q}) - $signed(13'(START_Y));
    px = 19'(dx) * 19'($signed({1'b0, cnt_inc}));
    py = 19'(dy) * 19'($signed({1'b0, cnt_inc}));
    sx = px >>> Shift;
    sy = py >>> Shift;
    bx = sx + $signed(19'(START_X));
    by = sy + $signed(19'(START_Y));

    ex = $signed({1'b0, ball_x_q}) - $signed({1'b0, keeper_x});
    ey = $signed({1'b0, ball_y_q}) - $signed({1'b0, keeper_y});
    ax = (ex < 0) ? -ex : ex;
    ay = (ey < 0) ? -ey : ey;
    saved = ($unsigned(ax) <= 13'(HIT_RADIUS)) && ($unsigned(ay) <= 13'(HIT_RADIUS));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    solo_d   = solo_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    tgt_x_d  = tgt_x_q;
    tgt_y_d  = tgt_y_q;
    scored_d = scored_q;
    round_d  = round_q;
    score_d  = score_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          solo_d   = solo;
          state_d  = StAim;
          cnt_d    = '0;
          round_d  = '0;
          score_d  = '0;
          scored_d = 1'b0;
          ball_x_d = 12'(START_X);
          ball_y_d = 12'(START_Y);
        end
      end
      StAim: begin
        cnt_d = '0;
        if (solo_q) begin
          tgt_x_d = solo_tx;
          tgt_y_d = solo_ty;
          state_d = StFlight;
        end else if (remote_valid) begin
          tgt_x_d = clamp_x;
          tgt_y_d = clamp_y;
          state_d = StFlight;
        end
      end
      StFlight: begin
        if (frame_tick) begin
          cnt_d    = cnt_inc;
          ball_x_d = bx[11:0];
          ball_y_d = by[11:0];
          if (cnt_inc == 7'(FLIGHT_FRAMES)) begin
            state_d = StJudge;
            cnt_d   = '0;
          end
        end
      end
      StJudge: begin
        scored_d = !saved;
        if (!saved && score_q != 4'hF) score_d = score_q + 4'd1;
        if (round_q != 4'hF) round_d = round_q + 4'd1;
        state_d = StResult;
      end
      StResult: begin
        if (frame_tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == 7'(RESULT_FRAMES)) begin
            cnt_d = '0;
            if (round_q == 4'(ROUNDS)) begin
              state_d = StDone;
            end else begin
              scored_d = 1'b0;
              ball_x_d = 12'(START_X);
              ball_y_d = 12'(START_Y);
              state_d  = StAim;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    shot_req_d = (state_d == StAim) && !solo_d;
    over_d     = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      lfsr_q     <= 16'hACE1;
      cnt_q      <= '0;
      solo_q     <= 1'b0;
      ball_x_q   <= 12'(START_X);
      ball_y_q   <= 12'(START_Y);
      tgt_x_q    <= 12'(START_X);
      tgt_y_q    <= 12'(START_Y);
      shot_req_q <= 1'b0;
      scored_q   <= 1'b0;
      round_q    <= '0;
      score_q    <= '0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      solo_q     <= solo_d;
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      tgt_x_q    <= tgt_x_d;
      tgt_y_q    <= tgt_y_d;
      shot_req_q <= shot_req_d;
      scored_q   <= scored_d;
      round_q    <= round_d;
      score_q    <= score_d;
      over_q     <= over_d;
    end
  end

  assign ball_x        = ball_x_q;
  assign ball_y        = ball_y_q;
  assign target_x      = tgt_x_q;
  assign target_y      = tgt_y_q;
  assign shot_req      = shot_req_q;
  assign is_scored     = scored_q;
  assign round_counter = round_q;
  assign score         = score_q;
  assign game_over     = over_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with default parameters.
module tb_round_sequencer;

  logic        clk = 1'b0;
  logic        rst, frame_tick, start, solo, remote_valid;
  logic [11:0] remote_x, remote_y, keeper_x, keeper_y;
  logic [11:0] ball_x, ball_y, target_x, target_y;
  logic        shot_req, is_scored, game_over;
  logic [3:0]  round_counter, score;
  logic [2:0]  state_o;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  round_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .start        (start),
    .solo         (solo),
    .remote_valid (remote_valid),
    .remote_x     (remote_x),
    .remote_y     (remote_y),
    .keeper_x     (keeper_x),
    .keeper_y     (keeper_y),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .target_x     (target_x),
    .target_y     (target_y),
    .shot_req     (shot_req),
    .is_scored    (is_scored),
    .round_counter(round_counter),
    .score        (score),
    .game_over    (game_over),
    .state_o      (state_o)
  );

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) cyc();
    frame_tick = 1'b0;
  endtask

  task automatic shot(input int x, input int y);
    remote_x = 12'(x);
    remote_y = 12'(y);
    remote_valid = 1'b1;
    cyc();
    remote_valid = 1'b0;
    ticks(32);
    cyc();
    ticks(60);
  endtask

  initial begin
    rst = 1'b1; frame_tick = 0; start = 0; solo = 0; remote_valid = 0;
    remote_x = 0; remote_y = 0; keeper_x = 0; keeper_y = 0;
    cyc(); cyc();
    check("rst_state", state_o, 0);
    check("rst_ball_x", ball_x, 512);
    check("rst_ball_y", ball_y, 700);
    check("rst_tgt_x", target_x, 512);
    check("rst_score", score, 0);
    check("rst_round", round_counter, 0);
    check("rst_over", game_over, 0);
    check("rst_req", shot_req, 0);

    // Multi clamp, remote_valid coinciding with frame_tick.
    rst = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    check("aim_state", state_o, 1);
    check("aim_req", shot_req, 1);
    remote_x = 12'd2000; remote_y = 12'd50; remote_valid = 1'b1; frame_tick = 1'b1;
    cyc();
    remote_valid = 1'b0; frame_tick = 1'b0;
    check("clamp_x", target_x, 989);
    check("clamp_y", target_y, 115);
    check("clamp_req", shot_req, 0);
    check("clamp_state", state_o, 2);
    check("tick_ignored_x", ball_x, 512);
    ticks(32);
    check("land_x", ball_x, 989);
    check("land_y", ball_y, 115);
    check("land_state", state_o, 3);
    keeper_x = 12'd960; keeper_y = 12'd150;
    cyc();
    check("save1_state", state_o, 4);
    check("save1_scored", is_scored, 0);
    check("save1_round", round_counter, 1);
    ticks(60);
    check("ret_state", state_o, 1);
    check("ret_ball_y", ball_y, 700);

    // Flight interpolation, start ignored mid-flight, save.
    remote_x = 12'd832; remote_y = 12'd380; remote_valid = 1'b1; cyc(); remote_valid = 1'b0;
    ticks(16);
    check("mid_x", ball_x, 672);
    check("mid_y", ball_y, 540);
    start = 1'b1; cyc(); start = 1'b0;
    check("start_ignored", state_o, 2);
    ticks(16);
    check("end_x", ball_x, 832);
    check("end_y", ball_y, 380);
    check("end_state", state_o, 3);
    keeper_x = 12'd800; keeper_y = 12'd400;
    cyc();
    check("save2_scored", is_scored, 0);
    check("save2_score", score, 0);
    check("save2_round", round_counter, 2);
    ticks(60);

    // Goal, and the result hold boundary.
    keeper_x = 12'd100; keeper_y = 12'd100;
    remote_valid = 1'b1; cyc(); remote_valid = 1'b0;
    ticks(32);
    cyc();
    check("goal_scored", is_scored, 1);
    check("goal_score", score, 1);
    check("goal_round", round_counter, 3);
    ticks(59);
    check("hold_state", state_o, 4);
    check("hold_scored", is_scored, 1);
    check("hold_ball_x", ball_x, 832);
    ticks(1);
    check("hold_end_state", state_o, 1);
    check("hold_end_scored", is_scored, 0);

    keeper_x = 12'd0; keeper_y = 12'd0;
    shot(832, 380);
    shot(832, 380);
    check("done1_state", state_o, 5);
    check("done1_over", game_over, 1);
    check("done1_score", score, 3);
    check("done1_round", round_counter, 5);
    check("done1_ball_x", ball_x, 832);
    ticks(5);
    check("done1_hold", state_o, 5);

    // Restart from DONE, full match of goals.
    start = 1'b1; cyc(); start = 1'b0;
    check("restart_state", state_o, 1);
    check("restart_round", round_counter, 0);
    check("restart_score", score, 0);
    check("restart_over", game_over, 0);
    repeat (5) shot(832, 380);
    check("match_score", score, 5);
    check("match_round", round_counter, 5);
    check("match_over", game_over, 1);
    check("match_state", state_o, 5);

    // Solo targets from many LFSR phases.
    for (int i = 0; i < 200; i++) begin
      rst = 1'b1; cyc(); rst = 1'b0;
      repeat (i) cyc();
      solo = 1'b1; start = 1'b1; cyc(); start = 1'b0;
      check("solo_req", shot_req, 0);
      cyc();
      check("solo_in_range", int'(target_x >= 35 && target_x <= 989 &&
                                  target_y >= 115 && target_y <= 644), 1);
    end
    check("solo_state", state_o, 2);

    // Reset mid-flight.
    ticks(10);
    rst = 1'b1; cyc(); rst = 1'b0;
    check("midrst_state", state_o, 0);
    check("midrst_ball_x", ball_x, 512);
    check("midrst_ball_y", ball_y, 700);
    check("midrst_tgt_y", target_y, 700);
    check("midrst_round", round_counter, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Sequencer for one penalty match. It picks or receives each shot target and animates the ball from the penalty spot to the target, one step per video frame. It then judges save or goal against the keeper position and keeps the round and score counters. It sits between the input side (mouse, remote player link) and the ball and keeper drawing stages, and drives their ball coordinates.

## Interface

Parameters:
- ROUNDS, 5: number of shots per match.
- FLIGHT_FRAMES, 32: frames per shot flight. Must be a power of two, at most 32.
- START_X, 512 / START_Y, 700: penalty spot.
- GOAL_X_MIN, 35 / GOAL_X_MAX, 989: horizontal target bounds, inclusive.
- GOAL_Y_MIN, 115 / GOAL_Y_MAX, 644: vertical target bounds, inclusive.
- HIT_RADIUS, 64: per-axis save distance.
- RESULT_FRAMES, 60: frames the result is held.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- frame_tick, in, 1: one-cycle pulse per frame.
- start, in, 1: one-cycle pulse that begins a match.
- solo, in, 1: 1 = random targets, 0 = remote shooter. Sampled on an accepted start.
- remote_valid, in, 1: remote target strobe.
- remote_x / remote_y, in, 12 each: remote target coordinates.
- keeper_x / keeper_y, in, 12 each: keeper centre.
- ball_x / ball_y, out, 12 each: current ball position.
- target_x / target_y, out, 12 each: latched shot target.
- shot_req, out, 1: waiting for a remote target.
- is_scored, out, 1: last shot was a goal. Valid in RESULT.
- round_counter, out, 4: shots completed.
- score, out, 4: goals scored.
- game_over, out, 1: match finished.
- state_o, out, 3: IDLE=0, AIM=1, FLIGHT=2, JUDGE=3, RESULT=4, DONE=5.

## Operation

- **LFSR:** 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1. Advances every clk.
- **Solo target mapping** (valid for the default bounds):
  - X: rx = lfsr[9:0]. If rx > GOAL_X_MAX-GOAL_X_MIN, subtract (GOAL_X_MAX-GOAL_X_MIN+1). target_x = GOAL_X_MIN + rx.
  - Y: same rule using lfsr[15:6] and the Y bounds.
- **Multi target:** remote_x/remote_y are clamped into the goal bounds, each axis independently.
- **IDLE:** all counters 0. On start, latch solo and go to AIM.
- **AIM:**
  - Solo: latch the mapped LFSR target next cycle, then go to FLIGHT.
  - Multi: assert shot_req. On remote_valid, latch the clamped target, deassert shot_req, go to FLIGHT.
- **FLIGHT:**
  - Frame index f starts at 0 on entry.
  - Each frame_tick increments f.
  - ball = START + ((target − START)·f) >>> log2(FLIGHT_FRAMES). Difference is signed 13-bit, product is signed 19-bit, shift is arithmetic.
  - When f reaches FLIGHT_FRAMES, ball equals target exactly and the block goes to JUDGE.
- **JUDGE:** one cycle.
  - Saved when |ball_x−keeper_x| ≤ HIT_RADIUS and |ball_y−keeper_y| ≤ HIT_RADIUS. Unsigned compare after 13-bit signed subtraction.
  - Otherwise goal: is_scored=1 and score+1.
  - round_counter+1 in both cases.
  - Go to RESULT.
- **RESULT:**
  - Hold ball at target and hold is_scored for RESULT_FRAMES frame_ticks.
  - Then, if round_counter==ROUNDS, go to DONE. Otherwise clear is_scored, set ball to START, go to AIM.
- **DONE:** game_over=1. Ball, score and counters are held. On start: clear the counters, relatch solo, go to AIM.
- **Ignored inputs:**
  - start outside IDLE and DONE.
  - remote_valid outside AIM, or while in solo mode.
  - frame_tick outside FLIGHT and RESULT.

## Timing

- **Reset:** all outputs registered and 0 except ball_x/ball_y=START and target_x/target_y=START. State IDLE, LFSR at seed, f=0.
- **Reset mid-operation:** reaches reset values on the next edge. No partial round is counted.
- **State latency:** start→AIM in 1 cycle. AIM→FLIGHT in 1 cycle after entry (solo) or after remote_valid (multi).
- **Ball latency:** ball updates 1 cycle after frame_tick.
- **Judge latency:** JUDGE lasts exactly 1 cycle. score and round_counter update on JUDGE exit.
- **Simultaneous events:** remote_valid together with frame_tick in AIM takes the target; the tick is not counted. start together with rst: rst wins.
- **Counter width:** counters saturate at 15. This cannot be reached with ROUNDS≤15.

## Test plan

- **Reset values:** rst for 2 cycles → state_o=0, ball=(512,700), score=0, round_counter=0, game_over=0.
- **Multi clamp:** solo=0, start, then remote (2000,50) with remote_valid → shot_req drops, target=(989,115).
- **Flight interpolation:** multi, target (832,380). After 16 frame_ticks ball=(672,540). After 32 ticks ball=(832,380) and state goes JUDGE→RESULT.
- **Judge outcome:**
  - keeper (800,400): is_scored=0, score unchanged.
  - keeper (100,100): is_scored=1, score+1.
  - round_counter+1 in both cases.
- **Full match and restart:** 5 shots with keeper at (0,0) → score=5, round_counter=5, game_over=1, state DONE. A start in DONE then gives counters 0 and state AIM.
- **Solo, edges and reset:**
  - Solo: 200 random targets all within [35,989]×[115,644].
  - start mid-FLIGHT is ignored.
  - rst mid-FLIGHT → reset values next cycle.
